// File: rtl/stepdown_fault_recovery_pkg.sv
// stepdown_fault_pkg: shared state encoding, test-mode codes and timer-load helper
package stepdown_fault_pkg;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SOFTSTART = 3'd1,
        ST_RUN       = 3'd2,
        ST_COOLDOWN  = 3'd3,
        ST_LATCHED   = 3'd4
    } state_e;
    localparam logic [4:0] TM_FAST    = 5'h0D;
    localparam logic [4:0] TM_NORETRY = 5'h0E;
    localparam int         RETRY_W    = 4;
    // Fast mode shrinks a phase to (cyc>>4)+1 cycles; normal mode runs exactly cyc cycles.
    function automatic logic [31:0] timer_load(input logic [31:0] cyc, input logic fast);
        return fast ? cyc >> 4 : cyc - 32'd1;
    endfunction
endpackage

// File: rtl/stepdown_fault_recovery_if.sv
// stepdown_fault_recovery_if: request/fault inputs and enable/status outputs of the hiccup responder
//   master: drives enable_req, fault_short, ok_fault, tmi; observes the status outputs
//   slave : the responder itself
interface stepdown_fault_recovery_if;
    import stepdown_fault_pkg::*;
    logic               enable_req;
    logic               fault_short;
    logic               ok_fault;
    logic [4:0]         tmi;
    logic               enable_stepdown;
    logic               enable_fault;
    logic               hiccup_active;
    logic               latched_off;
    logic [RETRY_W-1:0] retry_count;
    logic [2:0]         state_obs;
    modport master (
        output enable_req, fault_short, ok_fault, tmi,
        input  enable_stepdown, enable_fault, hiccup_active, latched_off, retry_count, state_obs
    );
    modport slave (
        input  enable_req, fault_short, ok_fault, tmi,
        output enable_stepdown, enable_fault, hiccup_active, latched_off, retry_count, state_obs
    );
endinterface

// File: rtl/stepdown_fault_recovery_sync2.sv
// stepdown_sync2: two-flop synchroniser, cleared asynchronously by POR
//   CLK, POR : clock and async active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronised output, 2 cycles later
module stepdown_sync2 (
    input  logic CLK,
    input  logic POR,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge CLK or posedge POR) begin
        if (POR) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], d_i};
    end
    assign q_o = sync_q[1];
endmodule

// File: rtl/stepdown_fault_recovery.sv
// stepdown_fault_recovery: hiccup-mode fault responder driving stepdown and fault-detect enables
//   CLK, POR : clock and async active-high reset
//   bus      : slave side of stepdown_fault_recovery_if (request, fault flags, tmi in; enables, status out)
module stepdown_fault_recovery
    import stepdown_fault_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int BLANK_CYC = 1000,
    parameter int COOL_CYC  = 8000,
    parameter int GOOD_CYC  = 4000,
    parameter int MAX_RETRY = 7
) (
    input logic CLK,
    input logic POR,
    stepdown_fault_recovery_if.slave bus
);
    localparam int GOOD_W = $clog2(GOOD_CYC + 1);
    logic               fs_s, ok_s, fast, req;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d, blank_ld, cool_ld;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               es_q, ef_q, hic_q, lat_q;
    logic [2:0]         obs_q;
    stepdown_sync2 u_fs (.CLK(CLK), .POR(POR), .d_i(bus.fault_short), .q_o(fs_s));
    stepdown_sync2 u_ok (.CLK(CLK), .POR(POR), .d_i(bus.ok_fault), .q_o(ok_s));
    assign req       = bus.enable_req;
    assign fast      = bus.tmi == TM_FAST;
    assign blank_ld  = CNT_W'(timer_load(BLANK_CYC, fast));
    assign cool_ld   = CNT_W'(timer_load(COOL_CYC, fast));
    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        good_d  = '0;
        retry_d = retry_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SOFTSTART;
                    timer_d = blank_ld;
                end
            end
            ST_SOFTSTART: begin
                if (!req) state_d = ST_IDLE;
                else if (timer_q == '0) state_d = ST_RUN;
                else timer_d = timer_q - CNT_W'(1);
            end
            ST_RUN: begin
                // Fault outranks the good-streak clear when both land on the same cycle.
                if (!req) state_d = ST_IDLE;
                else if (fs_s) begin
                    state_d = ST_COOLDOWN;
                    timer_d = cool_ld;
                end else if (ok_s) begin
                    good_d = (good_q == GOOD_W'(GOOD_CYC)) ? good_q : good_q + GOOD_W'(1);
                    if (good_q >= GOOD_W'(GOOD_CYC - 1)) retry_d = '0;
                end
            end
            ST_COOLDOWN: begin
                if (!req) state_d = ST_IDLE;
                else if (timer_q == '0) begin
                    retry_d = retry_inc;
                    if (retry_inc >= RETRY_W'(MAX_RETRY) || bus.tmi == TM_NORETRY) state_d = ST_LATCHED;
                    else begin
                        state_d = ST_SOFTSTART;
                        timer_d = blank_ld;
                    end
                end else timer_d = timer_q - CNT_W'(1);
            end
            ST_LATCHED: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // Outputs are decoded from the current state and registered, so they trail transitions by one cycle.
    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            good_q  <= '0;
            retry_q <= '0;
            es_q    <= 1'b0;
            ef_q    <= 1'b0;
            hic_q   <= 1'b0;
            lat_q   <= 1'b0;
            obs_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            good_q  <= good_d;
            retry_q <= retry_d;
            es_q    <= state_q == ST_SOFTSTART || state_q == ST_RUN;
            ef_q    <= state_q == ST_RUN;
            hic_q   <= state_q == ST_COOLDOWN;
            lat_q   <= state_q == ST_LATCHED;
            obs_q   <= state_q;
        end
    end
    assign bus.enable_stepdown = es_q;
    assign bus.enable_fault    = ef_q;
    assign bus.hiccup_active   = hic_q;
    assign bus.latched_off     = lat_q;
    assign bus.retry_count     = retry_q;
    assign bus.state_obs       = obs_q;
endmodule

// File: tb/tb_stepdown_fault_recovery.sv
// tb_stepdown_fault_recovery: vector table, directed corner sequences and random run against a phase model
module tb_stepdown_fault_recovery;
    localparam int BLANK = 8, COOL = 16, GOOD = 10, MAXR = 3;
    localparam int S_IDLE = 0, S_SOFT = 1, S_RUN = 2, S_COOL = 3, S_LAT = 4;
    logic CLK, POR;
    int   total = 0, bad = 0;
    stepdown_fault_recovery_if sif ();
    stepdown_fault_recovery #(
        .CNT_W(16), .BLANK_CYC(BLANK), .COOL_CYC(COOL), .GOOD_CYC(GOOD), .MAX_RETRY(MAXR)
    ) dut (
        .CLK(CLK),
        .POR(POR),
        .bus(sif)
    );
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    // Phase model: each phase lasts a whole number of cycles, streaks and retries are plain integers.
    int         m_st, m_left, m_good, m_retry, m_obs;
    logic [1:0] fp, op;
    always @(posedge CLK or posedge POR) begin
        if (POR) begin
            m_st <= S_IDLE; m_left <= 0; m_good <= 0; m_retry <= 0; m_obs <= S_IDLE;
            fp <= 2'b00; op <= 2'b00;
        end else begin : mdl
            int st, left, good, retry, blank, cool;
            st    = m_st;
            left  = m_left;
            good  = 0;
            retry = m_retry;
            blank = (sif.tmi == 5'h0D) ? BLANK / 16 + 1 : BLANK;
            cool  = (sif.tmi == 5'h0D) ? COOL / 16 + 1 : COOL;
            if (st == S_IDLE) begin
                if (sif.enable_req) begin st = S_SOFT; left = blank; end
            end else if (st == S_LAT) begin
                if (!sif.enable_req) begin st = S_IDLE; retry = 0; end
            end else if (!sif.enable_req) st = S_IDLE;
            else if (st == S_SOFT) begin
                if (left == 1) st = S_RUN;
                else left = left - 1;
            end else if (st == S_RUN) begin
                if (fp[1]) begin st = S_COOL; left = cool; end
                else if (op[1]) begin
                    good = m_good + 1;
                    if (good >= GOOD) retry = 0;
                end
            end else if (left > 1) left = left - 1;
            else begin
                retry = (retry < 15) ? retry + 1 : 15;
                st    = (retry >= MAXR || sif.tmi == 5'h0E) ? S_LAT : S_SOFT;
                left  = blank;
            end
            m_st <= st; m_left <= left; m_good <= good; m_retry <= retry; m_obs <= m_st;
            fp <= {fp[0], sif.fault_short};
            op <= {op[0], sif.ok_fault};
        end
    end
    function automatic logic [10:0] outs();
        return {sif.enable_stepdown, sif.enable_fault, sif.hiccup_active, sif.latched_off,
                sif.retry_count, sif.state_obs};
    endfunction
    function automatic logic [10:0] exp_outs();
        return {m_obs == S_SOFT || m_obs == S_RUN, m_obs == S_RUN, m_obs == S_COOL, m_obs == S_LAT,
                4'(m_retry), 3'(m_obs)};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic por_pulse();
        @(negedge CLK);
        POR = 1'b1;
        @(negedge CLK);
        POR = 1'b0;
    endtask
    task automatic pulse();
        sif.fault_short = 1'b1;
        @(negedge CLK);
        sif.fault_short = 1'b0;
    endtask
    task automatic wait_state(input int s, input int budget, input string nm);
        int k = 0;
        while (sif.state_obs !== 3'(s) && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk(nm, 32'(sif.state_obs), 32'(s));
    endtask
    // From reset, two faulted retries, then a fault inside blanking, then RUN with ok_fault held high.
    task automatic to_run_retry2();
        por_pulse();
        sif.tmi = 5'h00; sif.ok_fault = 1'b0; sif.fault_short = 1'b0; sif.enable_req = 1'b1;
        wait_state(S_RUN, 40, "t4_run_a");
        pulse();
        wait_state(S_COOL, 10, "t4_cool_a");
        wait_state(S_SOFT, 40, "t4_soft_a");
        wait_state(S_RUN, 40, "t4_run_b");
        pulse();
        wait_state(S_COOL, 10, "t4_cool_b");
        wait_state(S_SOFT, 40, "t4_soft_b");
        chk("t4_retry2", 32'(sif.retry_count), 2);
        sif.ok_fault = 1'b1;
        pulse();
        repeat (4) @(negedge CLK);
        chk("t4_blanked", {sif.hiccup_active, sif.state_obs}, {1'b0, 3'd1});
        wait_state(S_RUN, 20, "t4_run_c");
    endtask
    typedef struct {
        bit         por;
        bit         req;
        bit         fs;
        bit         ok;
        logic [4:0] tmi;
        int         n;
        logic [3:0] flg;
        logic [3:0] rc;
        logic [2:0] obs;
    } vec_t;
    vec_t vt[26];
    int   hic_n, fs_pct, tsel;
    bit   prev_hic;
    initial begin
        POR = 1'b1;
        sif.enable_req = 1'b0; sif.fault_short = 1'b0; sif.ok_fault = 1'b0; sif.tmi = 5'h00;
        // {por, req, fs, ok, tmi, edges, {es,ef,hic,lat}, retry, state_obs}
        vt[0]  = '{1, 1, 0, 0, 5'h00,  0, 4'b0000, 4'd0, 3'd0};
        vt[1]  = '{0, 1, 0, 0, 5'h00,  1, 4'b0000, 4'd0, 3'd0};
        vt[2]  = '{0, 1, 0, 0, 5'h00,  1, 4'b1000, 4'd0, 3'd1};
        vt[3]  = '{0, 1, 0, 0, 5'h00,  7, 4'b1000, 4'd0, 3'd1};
        vt[4]  = '{0, 1, 0, 0, 5'h00,  1, 4'b1100, 4'd0, 3'd2};
        vt[5]  = '{0, 1, 1, 0, 5'h00,  1, 4'b1100, 4'd0, 3'd2};
        vt[6]  = '{0, 1, 0, 0, 5'h00,  2, 4'b1100, 4'd0, 3'd2};
        vt[7]  = '{0, 1, 0, 0, 5'h00,  1, 4'b0010, 4'd0, 3'd3};
        vt[8]  = '{0, 1, 0, 0, 5'h00, 15, 4'b0010, 4'd1, 3'd3};
        vt[9]  = '{0, 1, 0, 0, 5'h00,  1, 4'b1000, 4'd1, 3'd1};
        vt[10] = '{1, 1, 0, 0, 5'h0D,  0, 4'b0000, 4'd0, 3'd0};
        vt[11] = '{0, 1, 0, 0, 5'h0D,  2, 4'b1000, 4'd0, 3'd1};
        vt[12] = '{0, 1, 0, 0, 5'h0D,  1, 4'b1100, 4'd0, 3'd2};
        vt[13] = '{0, 1, 1, 0, 5'h0D,  1, 4'b1100, 4'd0, 3'd2};
        vt[14] = '{0, 1, 0, 0, 5'h0D,  2, 4'b1100, 4'd0, 3'd2};
        vt[15] = '{0, 1, 0, 0, 5'h0D,  1, 4'b0010, 4'd0, 3'd3};
        vt[16] = '{0, 1, 0, 0, 5'h0D,  1, 4'b0010, 4'd1, 3'd3};
        vt[17] = '{0, 1, 0, 0, 5'h0D,  1, 4'b1000, 4'd1, 3'd1};
        vt[18] = '{1, 1, 0, 0, 5'h0E, 10, 4'b1100, 4'd0, 3'd2};
        vt[19] = '{0, 1, 1, 0, 5'h0E,  1, 4'b1100, 4'd0, 3'd2};
        vt[20] = '{0, 1, 0, 0, 5'h0E,  2, 4'b1100, 4'd0, 3'd2};
        vt[21] = '{0, 1, 0, 0, 5'h0E,  1, 4'b0010, 4'd0, 3'd3};
        vt[22] = '{0, 1, 0, 0, 5'h0E, 15, 4'b0010, 4'd1, 3'd3};
        vt[23] = '{0, 1, 0, 0, 5'h0E,  1, 4'b0001, 4'd1, 3'd4};
        vt[24] = '{0, 0, 0, 0, 5'h0E,  1, 4'b0001, 4'd0, 3'd4};
        vt[25] = '{0, 0, 0, 0, 5'h0E,  1, 4'b0000, 4'd0, 3'd0};
        for (int i = 0; i < 26; i++) begin
            if (vt[i].por) por_pulse();
            sif.enable_req = vt[i].req; sif.fault_short = vt[i].fs;
            sif.ok_fault = vt[i].ok; sif.tmi = vt[i].tmi;
            repeat (vt[i].n) @(posedge CLK);
            if (vt[i].n > 0) @(negedge CLK);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'({vt[i].flg, vt[i].rc, vt[i].obs}));
        end
        // Permanent short: three hiccups, then latch-off until the request drops.
        por_pulse();
        sif.tmi = 5'h00; sif.ok_fault = 1'b0; sif.fault_short = 1'b1; sif.enable_req = 1'b1;
        hic_n = 0; prev_hic = 1'b0;
        for (int k = 0; k < 600 && !sif.latched_off; k++) begin
            @(negedge CLK);
            if (sif.hiccup_active && !prev_hic) hic_n++;
            prev_hic = sif.hiccup_active;
        end
        chk("t3_latched", 32'(sif.latched_off), 1);
        chk("t3_hiccups", 32'(hic_n), 3);
        chk("t3_retry", 32'(sif.retry_count), 3);
        chk("t3_es_off", 32'(sif.enable_stepdown), 0);
        sif.enable_req = 1'b0;
        @(negedge CLK);
        chk("t3_retry_clr", 32'(sif.retry_count), 0);
        @(negedge CLK);
        chk("t3_idle", {sif.latched_off, sif.state_obs}, {1'b0, 3'd0});
        sif.fault_short = 1'b0;
        // Ten good RUN cycles clear retry_count before the next fault.
        to_run_retry2();
        repeat (8) @(negedge CLK);
        chk("t4_pre_clear", 32'(sif.retry_count), 2);
        @(negedge CLK);
        chk("t4_clear", 32'(sif.retry_count), 0);
        pulse();
        wait_state(S_COOL, 10, "t4_cool_c");
        wait_state(S_SOFT, 40, "t4_soft_c");
        chk("t4_after", 32'(sif.retry_count), 1);
        // Fault arriving on the tenth good cycle wins: no clear, third failure latches.
        to_run_retry2();
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        pulse();
        wait_state(S_LAT, 100, "t4_collide_latch");
        chk("t4_collide_retry", 32'(sif.retry_count), 3);
        // POR in the middle of COOLDOWN clears outputs without a clock edge.
        por_pulse();
        sif.tmi = 5'h00; sif.ok_fault = 1'b0; sif.enable_req = 1'b1;
        wait_state(S_RUN, 40, "t5_run");
        pulse();
        wait_state(S_COOL, 10, "t5_cool");
        chk("t5_hic_on", 32'(sif.hiccup_active), 1);
        #2 POR = 1'b1;
        #1 chk("t5_por_async", 32'(outs()), 0);
        @(negedge CLK);
        POR = 1'b0;
        // Random run against the phase model.
        por_pulse();
        sif.enable_req = 1'b1; sif.tmi = 5'h00; fs_pct = 1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                sif.enable_req = !sif.enable_req;
                fs_pct = int'($urandom_range(0, 4));
                tsel = int'($urandom_range(0, 3));
                sif.tmi = (tsel == 0) ? 5'h0D : (tsel == 1) ? 5'h0E : (tsel == 2) ? 5'h00 : 5'h1B;
            end
            sif.fault_short = int'($urandom_range(0, 99)) < fs_pct;
            sif.ok_fault = $urandom_range(0, 99) < 92;
            @(negedge CLK);
            chk("rand", 32'(outs()), 32'(exp_outs()));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
